// File: rtl/quick_sort_pkg.sv
// Shared definitions for the quick-sort memory path: default word width and
// the swap sequencer state encoding.
package quick_sort_pkg;

  localparam int unsigned DEFAULT_WORD_SIZE = 16;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD1  = 3'd1,
    S_RD2  = 3'd2,
    S_CAP  = 3'd3,
    S_WR1  = 3'd4,
    S_WR2  = 3'd5,
    S_DONE = 3'd6
  } swap_state_e;

endpackage

// File: rtl/quick_sort_swap_fsm.sv
// Swap sequencer: turns one accepted swap into RD a1, RD a2, WR a1, WR a2
// and pulses done once both writes have been issued.
module quick_sort_swap_fsm
  import quick_sort_pkg::*;
#(
  parameter int unsigned WORD_SIZE = DEFAULT_WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WORD_SIZE-1:0] addr1,
  input  logic [WORD_SIZE-1:0] addr2,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic                 idle,
  output logic                 busy,
  output logic                 done,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata
);

  swap_state_e          state_q, state_d;
  logic [WORD_SIZE-1:0] a1_q, a1_d;
  logic [WORD_SIZE-1:0] a2_q, a2_d;
  logic [WORD_SIZE-1:0] d1_q, d1_d;
  logic [WORD_SIZE-1:0] d2_q, d2_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      a1_q    <= '0;
      a2_q    <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
    end else begin
      state_q <= state_d;
      a1_q    <= a1_d;
      a2_q    <= a2_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
    end
  end

  // Read data lags its access by one cycle, so d1 lands in RD2 and d2 in CAP.
  always_comb begin
    state_d = state_q;
    a1_d    = a1_q;
    a2_d    = a2_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a1_d    = addr1;
          a2_d    = addr2;
          state_d = (addr1 == addr2) ? S_DONE : S_RD1;
        end
      end
      S_RD1:   state_d = S_RD2;
      S_RD2: begin
        d1_d    = mem_rdata;
        state_d = S_CAP;
      end
      S_CAP: begin
        d2_d    = mem_rdata;
        state_d = S_WR1;
      end
      S_WR1:   state_d = S_WR2;
      S_WR2:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    idle      = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state_q)
      S_RD1: begin
        mem_en   = 1'b1;
        mem_addr = a1_q;
      end
      S_RD2: begin
        mem_en   = 1'b1;
        mem_addr = a2_q;
      end
      S_WR1: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = a1_q;
        mem_wdata = d2_q;
      end
      S_WR2: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = a2_q;
        mem_wdata = d1_q;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/quick_sort_mem_scheduler.sv
// Single-port sort memory owner: arbitrates swap engine, controller read and
// host access, muxes the memory port and returns read data with a valid flag.
module quick_sort_mem_scheduler
  import quick_sort_pkg::*;
#(
  parameter int unsigned WORD_SIZE = DEFAULT_WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 swap_req,
  input  logic [WORD_SIZE-1:0] swap_addr1,
  input  logic [WORD_SIZE-1:0] swap_addr2,
  output logic                 swap_gnt,
  output logic                 swap_busy,
  output logic                 swap_done,
  input  logic                 rd_req,
  input  logic [WORD_SIZE-1:0] rd_addr,
  output logic                 rd_gnt,
  output logic                 rd_valid,
  output logic [WORD_SIZE-1:0] rd_data,
  input  logic                 host_req,
  input  logic                 host_we,
  input  logic [WORD_SIZE-1:0] host_addr,
  input  logic [WORD_SIZE-1:0] host_wdata,
  output logic                 host_gnt,
  output logic                 host_rvalid,
  output logic [WORD_SIZE-1:0] host_rdata,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata
);

  logic                 fsm_idle;
  logic                 fsm_mem_en;
  logic                 fsm_mem_we;
  logic [WORD_SIZE-1:0] fsm_mem_addr;
  logic [WORD_SIZE-1:0] fsm_mem_wdata;
  logic                 rd_valid_q, rd_valid_d;
  logic                 host_rvalid_q, host_rvalid_d;

  quick_sort_swap_fsm #(
    .WORD_SIZE(WORD_SIZE)
  ) u_swap_fsm (
    .clk      (clk),
    .reset    (reset),
    .start    (swap_gnt),
    .addr1    (swap_addr1),
    .addr2    (swap_addr2),
    .mem_rdata(mem_rdata),
    .idle     (fsm_idle),
    .busy     (swap_busy),
    .done     (swap_done),
    .mem_en   (fsm_mem_en),
    .mem_we   (fsm_mem_we),
    .mem_addr (fsm_mem_addr),
    .mem_wdata(fsm_mem_wdata)
  );

  // Grants only while the sequencer is idle; losers keep their request up.
  always_comb begin
    swap_gnt = 1'b0;
    rd_gnt   = 1'b0;
    host_gnt = 1'b0;
    if (fsm_idle && !reset) begin
      swap_gnt = swap_req;
      rd_gnt   = rd_req && !swap_req;
      host_gnt = host_req && !swap_req && !rd_req;
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!fsm_idle) begin
      mem_en    = fsm_mem_en;
      mem_we    = fsm_mem_we;
      mem_addr  = fsm_mem_addr;
      mem_wdata = fsm_mem_wdata;
    end else if (rd_gnt) begin
      mem_en   = 1'b1;
      mem_addr = rd_addr;
    end else if (host_gnt) begin
      mem_en    = 1'b1;
      mem_we    = host_we;
      mem_addr  = host_addr;
      mem_wdata = host_we ? host_wdata : '0;
    end
  end

  always_comb begin
    rd_valid_d    = rd_gnt;
    host_rvalid_d = host_gnt && !host_we;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_q    <= 1'b0;
      host_rvalid_q <= 1'b0;
    end else begin
      rd_valid_q    <= rd_valid_d;
      host_rvalid_q <= host_rvalid_d;
    end
  end

  // The memory macro registers its output, so return data is passed straight through.
  always_comb begin
    rd_valid    = rd_valid_q;
    rd_data     = rd_valid_q ? mem_rdata : '0;
    host_rvalid = host_rvalid_q;
    host_rdata  = host_rvalid_q ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_quick_sort_mem_scheduler.sv
// Bench for quick_sort_mem_scheduler: transaction-level reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_quick_sort_mem_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        swap_req = 1'b0;
  logic [15:0] swap_addr1 = '0, swap_addr2 = '0;
  logic        swap_gnt, swap_busy, swap_done;
  logic        rd_req = 1'b0;
  logic [15:0] rd_addr = '0;
  logic        rd_gnt, rd_valid;
  logic [15:0] rd_data;
  logic        host_req = 1'b0, host_we = 1'b0;
  logic [15:0] host_addr = '0, host_wdata = '0;
  logic        host_gnt, host_rvalid;
  logic [15:0] host_rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  quick_sort_mem_scheduler #(.WORD_SIZE(16)) dut (
    .clk(clk), .reset(reset),
    .swap_req(swap_req), .swap_addr1(swap_addr1), .swap_addr2(swap_addr2),
    .swap_gnt(swap_gnt), .swap_busy(swap_busy), .swap_done(swap_done),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory macro: synchronous single port, read data one cycle after access.
  logic [15:0] ram [256];
  logic [15:0] ram_q = '0;
  initial for (int i = 0; i < 256; i++) ram[i] = '0;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
      else        ram_q <= ram[mem_addr[7:0]];
    end
  end
  assign mem_rdata = ram_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: memory contents, position within a swap, pending returns.
  logic [15:0] mmem [256];
  int          ph = 0;
  logic [15:0] ma1, ma2, v1, v2;
  bit          erv = 0, ehv = 0;
  logic [15:0] erd = '0, ehd = '0;
  logic        e_sg, e_rg, e_hg, e_en, e_we;
  logic [15:0] e_addr, e_wdata;
  initial for (int i = 0; i < 256; i++) mmem[i] = '0;

  always @(negedge clk) begin
    if (reset) begin
      ph = 0; erv = 0; ehv = 0;
    end else begin
      e_sg = 0; e_rg = 0; e_hg = 0; e_en = 0; e_we = 0; e_addr = '0; e_wdata = '0;
      if (ph == 0) begin
        e_sg = swap_req;
        e_rg = rd_req && !swap_req;
        e_hg = host_req && !swap_req && !rd_req;
        if (e_rg) begin e_en = 1; e_addr = rd_addr; end
        if (e_hg) begin
          e_en = 1; e_we = host_we; e_addr = host_addr;
          e_wdata = host_we ? host_wdata : '0;
        end
      end else if (ph == 1) begin e_en = 1; e_addr = ma1; end
      else if (ph == 2) begin e_en = 1; e_addr = ma2; end
      else if (ph == 4) begin e_en = 1; e_we = 1; e_addr = ma1; e_wdata = v2; end
      else if (ph == 5) begin e_en = 1; e_we = 1; e_addr = ma2; e_wdata = v1; end
      chk("m_swap_gnt", 32'(swap_gnt), 32'(e_sg));
      chk("m_swap_busy", 32'(swap_busy), 32'(ph != 0));
      chk("m_swap_done", 32'(swap_done), 32'(ph == 6));
      chk("m_rd_gnt", 32'(rd_gnt), 32'(e_rg));
      chk("m_host_gnt", 32'(host_gnt), 32'(e_hg));
      chk("m_rd_valid", 32'(rd_valid), 32'(erv));
      chk("m_rd_data", 32'(rd_data), erv ? 32'(erd) : 32'd0);
      chk("m_host_rvalid", 32'(host_rvalid), 32'(ehv));
      chk("m_host_rdata", 32'(host_rdata), ehv ? 32'(ehd) : 32'd0);
      chk("m_mem_en", 32'(mem_en), 32'(e_en));
      chk("m_mem_we", 32'(mem_we), 32'(e_we));
      chk("m_mem_addr", 32'(mem_addr), 32'(e_addr));
      chk("m_mem_wdata", 32'(mem_wdata), 32'(e_wdata));
      erv = e_rg;
      if (e_rg) erd = mmem[rd_addr[7:0]];
      ehv = e_hg && !host_we;
      if (ehv) ehd = mmem[host_addr[7:0]];
      if (e_hg && host_we) mmem[host_addr[7:0]] = host_wdata;
      if (ph == 0) begin
        if (e_sg) begin
          ma1 = swap_addr1; ma2 = swap_addr2;
          v1 = mmem[ma1[7:0]]; v2 = mmem[ma2[7:0]];
          ph = (ma1 == ma2) ? 6 : 1;
        end
      end else begin
        if (ph == 4) mmem[ma1[7:0]] = v2;
        if (ph == 5) mmem[ma2[7:0]] = v1;
        ph = (ph == 6) ? 0 : ph + 1;
      end
    end
  end

  logic [15:0] dump_v [8];

  task automatic host_load(input logic [15:0] vals [8]);
    for (int i = 0; i < 8; i++) begin
      host_req = 1; host_we = 1; host_addr = 16'(i); host_wdata = vals[i];
      @(negedge clk);
      chk("load_gnt_each_cycle", 32'(host_gnt), 1);
      @(posedge clk); #1;
    end
    host_req = 0; host_we = 0;
  endtask

  task automatic host_dump();
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin host_req = 1; host_we = 0; host_addr = 16'(i); end
      else host_req = 0;
      @(negedge clk);
      if (i < 8) chk("dump_gnt_each_cycle", 32'(host_gnt), 1);
      if (i > 0) begin
        chk("dump_rvalid", 32'(host_rvalid), 1);
        dump_v[i-1] = host_rdata;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic compare_dump(input string tag, input logic [15:0] exp [8]);
    for (int i = 0; i < 8; i++) chk(tag, 32'(dump_v[i]), 32'(exp[i]));
  endtask

  task automatic do_swap(input logic [15:0] a1, input logic [15:0] a2,
                         output int tg, output int td, output int nrd, output int nwr);
    bit got = 0;
    tg = -1; td = -1; nrd = 0; nwr = 0;
    swap_addr1 = a1; swap_addr2 = a2; swap_req = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (swap_gnt) begin tg = cyc; got = 1; end
      if (got && mem_en) begin if (mem_we) nwr++; else nrd++; end
      if (swap_done) begin td = cyc; break; end
      @(posedge clk); #1;
      if (got) swap_req = 0;
    end
    if (td < 0) chk("swap_timeout", 0, 1);
    @(posedge clk); #1;
    swap_req = 0;
  endtask

  logic [15:0] init_vals [8] = '{16'd5, 16'd3, 16'd8, 16'd1, 16'd9, 16'd2, 16'd7, 16'd4};
  logic [15:0] after_t2  [8] = '{16'd5, 16'd3, 16'd2, 16'd1, 16'd9, 16'd8, 16'd7, 16'd4};
  logic [15:0] final_v   [8] = '{16'd5, 16'd3, 16'd2, 16'd1, 16'd8, 16'd9, 16'd4, 16'd7};

  initial begin
    int tg, td, nrd, nwr, tr, trv, th, g1, g2, d1, d2;
    logic [15:0] rdd;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", 32'({swap_gnt, swap_busy, swap_done, rd_gnt, rd_valid,
                           host_gnt, host_rvalid, mem_en, mem_we}), 0);
    chk("reset_data", 32'(rd_data | host_rdata | mem_addr | mem_wdata), 0);
    @(posedge clk); #1;
    reset = 0;

    // 1: host load and readback
    host_load(init_vals);
    host_dump();
    compare_dump("t1_readback", init_vals);

    // 2: swap 2,5
    do_swap(16'd2, 16'd5, tg, td, nrd, nwr);
    chk("t2_latency", 32'(td - tg), 6);
    chk("t2_reads", 32'(nrd), 2);
    chk("t2_writes", 32'(nwr), 2);
    host_dump();
    compare_dump("t2_memory", after_t2);

    // 3: degenerate swap
    do_swap(16'd3, 16'd3, tg, td, nrd, nwr);
    chk("t3_latency", 32'(td - tg), 1);
    chk("t3_accesses", 32'(nrd + nwr), 0);
    host_dump();
    compare_dump("t3_memory", after_t2);

    // 4: simultaneous requests
    tg = -1; tr = -1; trv = -1; th = -1; rdd = '0;
    swap_addr1 = 16'd6; swap_addr2 = 16'd7; swap_req = 1;
    rd_addr = 16'd0; rd_req = 1;
    host_addr = 16'd1; host_we = 0; host_req = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (swap_gnt) tg = cyc;
      if (rd_gnt) tr = cyc;
      if (host_gnt) th = cyc;
      if (rd_valid) begin trv = cyc; rdd = rd_data; end
      @(posedge clk); #1;
      if (tg >= 0) swap_req = 0;
      if (tr >= 0) rd_req = 0;
      if (th >= 0) host_req = 0;
      if (th >= 0) break;
    end
    swap_req = 0; rd_req = 0; host_req = 0;
    chk("t4_rd_gnt_time", 32'(tr - tg), 7);
    chk("t4_rd_valid_time", 32'(trv - tg), 8);
    chk("t4_rd_data", 32'(rdd), 5);
    chk("t4_host_gnt_time", 32'(th - tg), 8);
    repeat (2) @(posedge clk); #1;

    // 5: reset during WR1
    swap_addr1 = 16'd4; swap_addr2 = 16'd5; swap_req = 1;
    tg = -1;
    for (int i = 0; i < 10 && tg < 0; i++) begin
      @(negedge clk);
      if (swap_gnt) tg = cyc;
      @(posedge clk); #1;
    end
    swap_req = 0;
    chk("t5_granted", 32'(tg >= 0), 1);
    repeat (3) @(posedge clk); #1;
    reset = 1;
    @(negedge clk);
    chk("t5_in_wr1", 32'(mem_we), 1);
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    chk("t5_post_ctrl", 32'({swap_gnt, swap_busy, swap_done, rd_gnt, rd_valid,
                             host_gnt, host_rvalid, mem_en, mem_we}), 0);
    chk("t5_post_data", 32'(rd_data | host_rdata | mem_addr | mem_wdata), 0);
    @(posedge clk); #1;
    host_req = 1; host_we = 1; host_addr = 16'd4; host_wdata = 16'd9;
    @(negedge clk); @(posedge clk); #1;
    host_addr = 16'd5; host_wdata = 16'd8;
    @(negedge clk); @(posedge clk); #1;
    host_req = 0; host_we = 0;
    do_swap(16'd4, 16'd5, tg, td, nrd, nwr);
    chk("t5_new_latency", 32'(td - tg), 6);

    // 6: back-to-back swaps
    g1 = -1; g2 = -1; d1 = -1; d2 = -1;
    swap_addr1 = 16'd0; swap_addr2 = 16'd1; swap_req = 1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (swap_gnt) begin if (g1 < 0) g1 = cyc; else g2 = cyc; end
      if (swap_done) begin if (d1 < 0) d1 = cyc; else d2 = cyc; end
      @(posedge clk); #1;
      if (g2 >= 0) swap_req = 0;
      else if (g1 >= 0) begin swap_addr1 = 16'd1; swap_addr2 = 16'd0; end
      if (d2 >= 0) break;
    end
    swap_req = 0;
    chk("t6_first_latency", 32'(d1 - g1), 6);
    chk("t6_regrant", 32'(g2 - d1), 1);
    chk("t6_second_latency", 32'(d2 - g2), 6);
    host_dump();
    compare_dump("t6_memory", final_v);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
